// File: rtl/stage_seq_pkg.sv
// Shared constants for the stage activation sequencer: FSM encoding,
// state width and stage indices of the default five-stage pipeline.
package stage_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_RESET  = 3'd0,
    SEQ_RAMP   = 3'd1,
    SEQ_RUN    = 3'd2,
    SEQ_DRAIN  = 3'd3,
    SEQ_HALTED = 3'd4
  } seq_state_t;

  // Stage indices for the default configuration (wb is the oldest stage).
  localparam int STG_WB  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_EX  = 2;
  localparam int STG_ID  = 3;
  localparam int STG_IF  = 4;

endpackage

// File: rtl/stage_stall_prefix.sv
// Prefix-OR of per-stage stalls: a stall at stage i also holds every
// younger (higher-index) stage upstream of it.
module stage_stall_prefix #(
  parameter int NUM_STAGES = 5
) (
  input  logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] stall_eff
);

  // Running OR from the oldest stage towards the youngest.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    stall_eff = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      acc          = acc | stall[i];
      stall_eff[i] = acc;
    end
  end

endmodule

// File: rtl/stage_act_sequencer.sv
// Sequenced pipeline activation: stages are enabled back-to-front after
// reset or resume, drained front-to-back into HALTED on request, gated by
// downstream stalls and fanned out per issue lane.
//
// Request/ack semantics: halt_req and resume_req are levels sampled on each
// active (ACT=1) clock edge. halt_req is honoured in RAMP/RUN and wins over
// resume_req; resume_req is honoured only in HALTED. halt_ack is high for
// exactly as long as the FSM sits in HALTED.
module stage_act_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int LANES      = 2,
  parameter int GAP        = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ACT,
  input  logic                          halt_req,
  input  logic                          resume_req,
  input  logic [NUM_STAGES-1:0]         stall,
  input  logic [LANES-1:0]              lane_en,
  output logic [NUM_STAGES-1:0]         stage_ACT,
  output logic [NUM_STAGES*LANES-1:0]   lane_ACT,
  output logic                          halt_ack,
  output logic [SEQ_STATE_W-1:0]        seq_state
);

  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0]         RELOAD   = GW'(GAP - 1);
  localparam logic [NUM_STAGES-1:0] ALL_ON   = '1;
  localparam logic [NUM_STAGES-1:0] FIRST_ON = NUM_STAGES'(1);

  seq_state_t            state_q, state_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [NUM_STAGES-1:0] stall_eff;

  stage_stall_prefix #(.NUM_STAGES(NUM_STAGES)) u_prefix (
    .stall     (stall),
    .stall_eff (stall_eff)
  );

  // State, mask and gap counter; ACT=0 holds them via the next-state logic.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SEQ_RESET;
      mask_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state: the mask is always a contiguous run of ones from stage 0,
  // so ramping sets the lowest clear bit and draining is a right shift.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    gap_d   = gap_q;
    if (ACT) begin
      unique case (state_q)
        SEQ_RESET, SEQ_HALTED: begin
          if (state_q == SEQ_RESET || resume_req) begin
            mask_d  = FIRST_ON;
            gap_d   = RELOAD;
            state_d = (FIRST_ON == ALL_ON) ? SEQ_RUN : SEQ_RAMP;
          end
        end
        SEQ_RAMP, SEQ_RUN: begin
          if (halt_req) begin
            mask_d  = mask_q >> 1;
            gap_d   = RELOAD;
            state_d = (mask_d == '0) ? SEQ_HALTED : SEQ_DRAIN;
          end else if (state_q == SEQ_RAMP) begin
            if (gap_q == '0) begin
              mask_d  = mask_q | (mask_q + FIRST_ON);
              gap_d   = RELOAD;
              state_d = (mask_d == ALL_ON) ? SEQ_RUN : SEQ_RAMP;
            end else begin
              gap_d = gap_q - GW'(1);
            end
          end
        end
        SEQ_DRAIN: begin
          if (gap_q == '0) begin
            mask_d  = mask_q >> 1;
            gap_d   = RELOAD;
            state_d = (mask_d == '0) ? SEQ_HALTED : SEQ_DRAIN;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        default: begin
          state_d = SEQ_RESET;
          mask_d  = '0;
          gap_d   = '0;
        end
      endcase
    end
  end

  // Per-stage and per-lane activation, combinational in ACT, stall, lane_en.
  always_comb begin
    stage_ACT = {NUM_STAGES{ACT}} & mask_q & ~stall_eff;
    lane_ACT  = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      for (int l = 0; l < LANES; l++) begin
        lane_ACT[i*LANES + l] = stage_ACT[i] & lane_en[l];
      end
    end
  end

  assign halt_ack  = (state_q == SEQ_HALTED);
  assign seq_state = state_q;

endmodule

// File: tb/tb_stage_act_sequencer.sv
// Bench for stage_act_sequencer: a GAP=1 and a GAP=3 instance share one
// stimulus stream; a stage-count model predicts every output each cycle,
// and directed sequences pin the model with literal expectations.
module tb_stage_act_sequencer;

  localparam int N = 5;
  localparam int L = 2;

  // ---------------- clock / reset / inputs ----------------
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         ACT = 1'b1;
  logic         halt_req = 1'b0;
  logic         resume_req = 1'b0;
  logic [N-1:0] stall = '0;
  logic [L-1:0] lane_en = '1;

  always #5 CLK = ~CLK;

  logic [N-1:0]   sa1, sa3;
  logic [N*L-1:0] la1, la3;
  logic           ha1, ha3;
  logic [2:0]     ss1, ss3;

  stage_act_sequencer #(.NUM_STAGES(N), .LANES(L), .GAP(1)) dut (
    .CLK(CLK), .RST(RST), .ACT(ACT), .halt_req(halt_req), .resume_req(resume_req),
    .stall(stall), .lane_en(lane_en), .stage_ACT(sa1), .lane_ACT(la1),
    .halt_ack(ha1), .seq_state(ss1)
  );

  stage_act_sequencer #(.NUM_STAGES(N), .LANES(L), .GAP(3)) dut3 (
    .CLK(CLK), .RST(RST), .ACT(ACT), .halt_req(halt_req), .resume_req(resume_req),
    .stall(stall), .lane_en(lane_en), .stage_ACT(sa3), .lane_ACT(la3),
    .halt_ack(ha3), .seq_state(ss3)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is described by how many stages are on (always the
  // oldest ones), a phase (0 idle,1 up,2 full,3 down,4 halted) and the
  // cycles left before the next one-stage step.
  int gaps[2] = '{1, 3};
  int m_on[2];
  int m_ph[2];
  int m_wt[2];
  bit model_live = 0;

  task automatic model_start(input int k);
    m_on[k] = 1;
    m_wt[k] = gaps[k] - 1;
    m_ph[k] = (m_on[k] == N) ? 2 : 1;
  endtask

  task automatic model_down(input int k);
    m_on[k] = m_on[k] - 1;
    m_wt[k] = gaps[k] - 1;
    m_ph[k] = (m_on[k] == 0) ? 4 : 3;
  endtask

  task automatic model_step(input int k);
    if (RST) begin
      m_on[k] = 0; m_ph[k] = 0; m_wt[k] = 0;
    end else if (ACT) begin
      case (m_ph[k])
        0: model_start(k);
        4: if (resume_req) model_start(k);
        1, 2: begin
          if (halt_req) model_down(k);
          else if (m_ph[k] == 1) begin
            if (m_wt[k] == 0) begin
              m_on[k] = m_on[k] + 1;
              m_wt[k] = gaps[k] - 1;
              if (m_on[k] == N) m_ph[k] = 2;
            end else m_wt[k] = m_wt[k] - 1;
          end
        end
        3: begin
          if (m_wt[k] == 0) model_down(k);
          else m_wt[k] = m_wt[k] - 1;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [N-1:0] model_stage(input int k);
    logic [N-1:0] r;
    bit held;
    held = 0;
    for (int i = 0; i < N; i++) begin
      held = held | stall[i];
      r[i] = ACT && (i < m_on[k]) && !held;
    end
    return r;
  endfunction

  function automatic logic [N*L-1:0] model_lane(input logic [N-1:0] s);
    logic [N*L-1:0] r;
    for (int i = 0; i < N; i++)
      for (int l = 0; l < L; l++)
        r[i*L + l] = s[i] & lane_en[l];
    return r;
  endfunction

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) model_step(k);
    model_live = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (model_live) begin
      logic [N-1:0] e1, e3;
      e1 = model_stage(0);
      e3 = model_stage(1);
      chk("m1_stage", 32'(sa1), 32'(e1));
      chk("m1_lane",  32'(la1), 32'(model_lane(e1)));
      chk("m1_ack",   32'(ha1), 32'(m_ph[0] == 4));
      chk("m1_state", 32'(ss1), 32'(m_ph[0]));
      chk("m3_stage", 32'(sa3), 32'(e3));
      chk("m3_lane",  32'(la3), 32'(model_lane(e3)));
      chk("m3_ack",   32'(ha3), 32'(m_ph[1] == 4));
      chk("m3_state", 32'(ss3), 32'(m_ph[1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [N-1:0] ramp_tab[5] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
  logic [N-1:0] drain_tab[5] = '{5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};

  initial begin
    int hp;
    ticks(3);
    chk("rst_stage", 32'(sa1), 32'h0);
    chk("rst_lane",  32'(la1), 32'h0);
    chk("rst_ack",   32'(ha1), 32'h0);
    chk("rst_state", 32'(ss1), 32'h0);

    // Ramp after reset release.
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ramp1", 32'(sa1), 32'(ramp_tab[i]));
    end
    chk("ramp1_run", 32'(ss1), 32'd2);
    chk("ramp3_e4", 32'(sa3), 32'(5'b00011));
    ticks(7);
    chk("ramp3_e11", 32'(sa3), 32'(5'b01111));
    tick();
    chk("ramp3_e12", 32'(sa3), 32'(5'b11111));
    chk("ramp3_run", 32'(ss3), 32'd2);

    // Stall and lane masking in RUN.
    stall = 5'b00100; lane_en = 2'b01; #1;
    chk("stall_stage", 32'(sa1), 32'(5'b00011));
    chk("stall_lane",  32'(la1), 32'(10'b0000000101));
    stall = '0; lane_en = 2'b11;

    // Drain from RUN.
    halt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drain1", 32'(sa1), 32'(drain_tab[i]));
    end
    chk("drain1_ack",   32'(ha1), 32'd1);
    chk("drain1_state", 32'(ss1), 32'd4);
    ticks(8);
    chk("drain3_ack", 32'(ha3), 32'd1);
    halt_req = 1'b0;

    // Resume, then halt mid-ramp at 00111.
    resume_req = 1'b1;
    tick();
    chk("resume", 32'(sa1), 32'(5'b00001));
    resume_req = 1'b0;
    ticks(2);
    chk("mid_ramp", 32'(sa1), 32'(5'b00111));
    halt_req = 1'b1;
    tick();
    chk("rev1", 32'(sa1), 32'(5'b00011));
    halt_req = 1'b0;
    tick();
    chk("rev2", 32'(sa1), 32'(5'b00001));
    tick();
    chk("rev3", 32'(sa1), 32'(5'b00000));
    chk("rev_state", 32'(ss1), 32'd4);

    // halt_req and resume_req together in RUN -> drain.
    resume_req = 1'b1;
    ticks(5);
    resume_req = 1'b0;
    chk("rerun", 32'(ss1), 32'd2);
    halt_req = 1'b1; resume_req = 1'b1;
    tick();
    chk("both_stage", 32'(sa1), 32'(5'b01111));
    chk("both_state", 32'(ss1), 32'd3);
    halt_req = 1'b0; resume_req = 1'b0;

    // Reset in the middle of a drain.
    tick();
    RST = 1'b1;
    tick();
    chk("mrst_stage", 32'(sa1), 32'h0);
    chk("mrst_lane",  32'(la1), 32'h0);
    chk("mrst_state", 32'(ss1), 32'd0);
    chk("mrst3_state", 32'(ss3), 32'd0);
    RST = 1'b0;

    // ACT low freezes a ramp.
    ticks(2);
    chk("pre_freeze", 32'(sa1), 32'(5'b00011));
    ACT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("frz_stage", 32'(sa1), 32'h0);
      chk("frz_state", 32'(ss1), 32'd1);
      tick();
    end
    ACT = 1'b1; #1;
    chk("thaw_stage", 32'(sa1), 32'(5'b00011));
    tick();
    chk("thaw_next", 32'(sa1), 32'(5'b00111));

    // Randomised traffic checked by the per-cycle model compare.
    for (int c = 0; c < 3000; c++) begin
      hp = (c < 1500) ? 63 : 7;
      RST        = ($urandom_range(0, 199) == 0);
      ACT        = ($urandom_range(0, 7) != 0);
      halt_req   = ($urandom_range(0, hp) == 0);
      resume_req = ($urandom_range(0, 5) == 0);
      stall      = N'($urandom & $urandom & $urandom);
      lane_en    = L'($urandom);
      tick();
    end

    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
